usb_rx_ctrl: RTL and testbench
==============================

Name: usb_rx_ctrl

Overview:
- Receive control unit for the USB full-speed receiver.
- Consumes the synchronized transition pulse from the d_plus edge detector and the EOP flag.
- Recovers bit timing by resyncing on every edge and generates shift strobes for the external receive shift register.
- Sequences each packet: SYNC check, data-byte writes to the RX FIFO, EOP handling and error flagging.

Parameters:
- CLKS_PER_BIT, 8, system clocks per USB bit period.
- SAMPLE_PHASE, 3, clk_cnt value at which a bit is sampled (0 <= SAMPLE_PHASE < CLKS_PER_BIT).
- SYNC_BYTE, 8'h80, required first byte as presented on rcv_data (LSB-first arrival).

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- d_edge  in  1  one-cycle pulse per d_plus transition.
- eop  in  1  SE0 currently present on the bus.
- rcv_data  in  8  parallel contents of the external shift register.
- rcving  out  1  packet in progress.
- shift_enable  out  1  one-cycle strobe: shift register captures the current bit.
- byte_received  out  1  one-cycle pulse: 8 bits shifted.
- w_enable  out  1  one-cycle FIFO write strobe.
- r_error  out  1  sticky receive error flag.

Behaviour:
- Reset (n_rst low, asynchronous): state IDLE, clk_cnt=0, bit_cnt=0, all outputs 0.
- Timer:
  - Runs only while state != IDLE.
  - clk_cnt increments each clk and wraps at CLKS_PER_BIT-1 -> 0.
  - d_edge forces clk_cnt to 0 next cycle (resync); edge takes priority over wrap.
- Sample tick: timer running and clk_cnt==SAMPLE_PHASE.
  - shift_enable = tick & ~eop (combinational from registered state).
  - eop_tick = tick & eop.
- Bit counter:
  - bit_cnt (3 bits) increments on shift_enable and wraps 7 -> 0.
  - byte_received is registered: high the cycle after the shift_enable that wraps bit_cnt.
  - bit_cnt clears in IDLE.
- FSM states:
  - IDLE: rcving=0. On d_edge -> SYNC_WAIT; clears r_error and counters.
  - SYNC_WAIT: byte_received -> SYNC_CHK; eop_tick -> ERROR.
  - SYNC_CHK (1 cycle): rcv_data==SYNC_BYTE -> RECEIVE, else -> ERROR.
  - RECEIVE:
    - byte_received -> STORE.
    - eop_tick with bit_cnt==0 -> EOP_WAIT (clean end).
    - eop_tick with bit_cnt!=0 -> ERROR.
  - STORE: w_enable=1 for exactly this one cycle -> RECEIVE.
  - EOP_WAIT: d_edge (SE0 -> J) -> IDLE.
  - ERROR: r_error<=1. eop_tick -> ERR_WAIT.
  - ERR_WAIT: d_edge -> IDLE; r_error stays 1.
- rcving=1 in every state except IDLE.
- r_error: set on ERROR entry; held through IDLE; cleared only by reset or the next packet start (IDLE -> SYNC_WAIT).
- Simultaneous events:
  - byte_received in the same cycle as eop_tick cannot occur (eop suppresses shift).
  - d_edge in the same cycle as tick: the tick is honoured and clk_cnt resyncs next cycle.
- Reset mid-packet: immediate return to IDLE, all outputs 0, no partial write.

Optional Feature:
- Macro: USB_RX_STUFF_TIMEOUT_EN.
- Defined: an idle-bit counter counts ticks since the last d_edge and clears on d_edge.
  - Reaching 7 ticks with no edge while in SYNC_WAIT or RECEIVE (bit-stuff violation) -> ERROR.
  - Reaching 7 ticks in EOP_WAIT or ERR_WAIT -> IDLE (stuck-bus recovery).
- Not defined: the counter is absent and no timeout transitions exist.

Decomposition:
- Package usb_rx_pkg:
  - enum rx_state_t {IDLE, SYNC_WAIT, SYNC_CHK, RECEIVE, STORE, EOP_WAIT, ERROR, ERR_WAIT}.
  - Default constants CLKS_PER_BIT, SAMPLE_PHASE, SYNC_BYTE.
- Sub-module rx_bit_timer (clk_cnt, bit_cnt, tick, shift_enable, byte_received) instantiated by usb_rx_ctrl; the FSM stays in usb_rx_ctrl.

Test Plan:
- Reset mid-RECEIVE (n_rst low between clocks) -> all outputs 0 immediately; after release, state IDLE, no w_enable.
- SYNC then data 8'hA5 then clean EOP, edges every 8 clks:
  - shift_enable 3 clks after each edge.
  - byte_received twice.
  - w_enable exactly once, 1 cycle after the second byte_received.
  - rcving drops on the edge ending EOP; r_error=0.
- First byte 8'h81 -> SYNC_CHK -> ERROR:
  - r_error=1, no w_enable.
  - r_error stays 1 after EOP and IDLE; clears on the next packet's first edge.
- EOP after 4 data bits -> ERROR; r_error=1; return to IDLE on the following d_edge.
- Jitter: edges at 7 and 9 clk spacing -> exactly one shift_enable per bit; clk_cnt resyncs to 0 each edge; correct byte captured.
- With USB_RX_STUFF_TIMEOUT_EN: 7 bit times without an edge in RECEIVE -> ERROR, r_error=1. Without the macro: same stimulus -> no error, byte_received still pulses.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared state encoding and default timing constants for the USB full-speed receive controller
package usb_rx_pkg;
  typedef enum logic [2:0] {
    IDLE,
    SYNC_WAIT,
    SYNC_CHK,
    RECEIVE,
    STORE,
    EOP_WAIT,
    ERROR,
    ERR_WAIT
  } rx_state_t;
  localparam int DEF_CLKS_PER_BIT = 8;
  localparam int DEF_SAMPLE_PHASE = 3;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'h80;
endpackage

// File: rtl/usb_rx_ctrl_timer.sv
// rx_bit_timer: edge-resynced bit clock, shift strobes and bit/byte counting for usb_rx_ctrl
// USB_RX_STUFF_TIMEOUT_EN adds a ticks-since-last-edge counter for bit-stuff/stuck-bus detection.
module rx_bit_timer import usb_rx_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int SAMPLE_PHASE = DEF_SAMPLE_PHASE
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       run_i,
  input  logic       d_edge_i,
  input  logic       eop_i,
  output logic       shift_enable_o,
  output logic       eop_tick_o,
  output logic       byte_received_o,
  output logic [2:0] bit_cnt_o
`ifdef USB_RX_STUFF_TIMEOUT_EN
  ,
  output logic       stuff_to_o
`endif
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          byte_received_q, byte_received_d;
  logic          tick;
  always_comb begin
    tick            = run_i && clk_cnt_q == CW'(SAMPLE_PHASE);
    shift_enable_o  = tick && !eop_i;
    eop_tick_o      = tick && eop_i;
    // an edge wins over the natural wrap so the sample point tracks the transmitter
    clk_cnt_d       = (!run_i || d_edge_i || clk_cnt_q == CW'(CLKS_PER_BIT - 1)) ? '0 : clk_cnt_q + CW'(1);
    bit_cnt_d       = !run_i ? 3'd0 : shift_enable_o ? bit_cnt_q + 3'd1 : bit_cnt_q;
    byte_received_d = shift_enable_o && bit_cnt_q == 3'd7;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      clk_cnt_q       <= '0;
      bit_cnt_q       <= 3'd0;
      byte_received_q <= 1'b0;
    end else begin
      clk_cnt_q       <= clk_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      byte_received_q <= byte_received_d;
    end
  assign byte_received_o = byte_received_q;
  assign bit_cnt_o       = bit_cnt_q;
`ifdef USB_RX_STUFF_TIMEOUT_EN
  logic [2:0] idle_q, idle_d;
  always_comb idle_d = (!run_i || d_edge_i) ? 3'd0 : (tick && idle_q != 3'd7) ? idle_q + 3'd1 : idle_q;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) idle_q <= 3'd0;
    else        idle_q <= idle_d;
  assign stuff_to_o = idle_q == 3'd7;
`endif
endmodule

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: packet sequencer for the USB full-speed receiver (SYNC check, byte stores, EOP and error handling)
// USB_RX_STUFF_TIMEOUT_EN enables bit-stuff violation and stuck-bus timeouts.
module usb_rx_ctrl import usb_rx_pkg::*; #(
  parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int         SAMPLE_PHASE = DEF_SAMPLE_PHASE,
  parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       shift_enable,
  output logic       byte_received,
  output logic       w_enable,
  output logic       r_error
);
  rx_state_t  state_q, state_d;
  logic       r_error_q, r_error_d;
  logic       eop_tick;
  logic [2:0] bit_cnt;
  logic       stuff_to;
`ifdef USB_RX_STUFF_TIMEOUT_EN
  rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .SAMPLE_PHASE(SAMPLE_PHASE)) u_timer (
    .clk(clk), .n_rst(n_rst), .run_i(rcving), .d_edge_i(d_edge), .eop_i(eop),
    .shift_enable_o(shift_enable), .eop_tick_o(eop_tick), .byte_received_o(byte_received),
    .bit_cnt_o(bit_cnt), .stuff_to_o(stuff_to)
  );
`else
  rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .SAMPLE_PHASE(SAMPLE_PHASE)) u_timer (
    .clk(clk), .n_rst(n_rst), .run_i(rcving), .d_edge_i(d_edge), .eop_i(eop),
    .shift_enable_o(shift_enable), .eop_tick_o(eop_tick), .byte_received_o(byte_received),
    .bit_cnt_o(bit_cnt)
  );
  assign stuff_to = 1'b0;
`endif
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q   <= IDLE;
      r_error_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_error_q <= r_error_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = d_edge ? SYNC_WAIT : IDLE;
      SYNC_WAIT: state_d = byte_received ? SYNC_CHK : (eop_tick || stuff_to) ? ERROR : SYNC_WAIT;
      SYNC_CHK:  state_d = rcv_data == SYNC_BYTE ? RECEIVE : ERROR;
      RECEIVE:   state_d = byte_received ? STORE :
                           eop_tick ? (bit_cnt == 3'd0 ? EOP_WAIT : ERROR) :
                           stuff_to ? ERROR : RECEIVE;
      STORE:     state_d = RECEIVE;
      EOP_WAIT:  state_d = (d_edge || stuff_to) ? IDLE : EOP_WAIT;
      ERROR:     state_d = eop_tick ? ERR_WAIT : ERROR;
      ERR_WAIT:  state_d = (d_edge || stuff_to) ? IDLE : ERR_WAIT;
      default:   state_d = IDLE;
    endcase
    // error is sticky across IDLE until the next packet actually starts
    r_error_d = (state_q == IDLE && d_edge) ? 1'b0 : (state_d == ERROR) ? 1'b1 : r_error_q;
  end
  assign rcving   = state_q != IDLE;
  assign w_enable = state_q == STORE;
  assign r_error  = r_error_q;
endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb_usb_rx_ctrl: directed scoreboard bench for usb_rx_ctrl with a behavioural external shift register
module tb_usb_rx_ctrl;
  import usb_rx_pkg::*;
  logic clk = 1'b0;
  logic n_rst, d_edge, eop, cur_bit, chk_phase;
  logic [7:0] sr = 8'h00;
  logic rcving, shift_enable, byte_received, w_enable, r_error;
  int n_cmp = 0, n_err = 0;
  int ncyc = 0, last_edge = 0, last_br = 0, n_se = 0, n_br = 0, n_we = 0;
  logic prev_edge = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] s;

  usb_rx_ctrl dut (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop), .rcv_data(sr),
    .rcving(rcving), .shift_enable(shift_enable), .byte_received(byte_received),
    .w_enable(w_enable), .r_error(r_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (shift_enable) sr <= {cur_bit, sr[7:1]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (prev_edge) chk("clk_cnt_resync", 32'(dut.u_timer.clk_cnt_q), 0);
    if (shift_enable) begin
      n_se++;
      if (chk_phase) chk("se_phase", ncyc - last_edge, DEF_SAMPLE_PHASE + 1);
    end
    if (byte_received) begin
      n_br++;
      last_br = ncyc;
    end
    if (w_enable) begin
      n_we++;
      chk("we_after_br", ncyc - last_br, 1);
      chk("we_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("wdata", 32'(sr), 32'(exp_q.pop_front()));
    end
    if (d_edge) last_edge = ncyc;
    prev_edge = d_edge;
  end

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_se = 0;
    n_br = 0;
    n_we = 0;
  endtask

  task automatic send_bit(input logic b, input int gap);
    cur_bit = b;
    d_edge = 1'b1;
    tick1();
    d_edge = 1'b0;
    repeat (gap - 1) tick1();
  endtask

  task automatic send_byte(input logic [7:0] v, input bit jitter);
    for (int i = 0; i < 8; i++) send_bit(v[i], jitter ? ((i % 2) ? 9 : 7) : 8);
  endtask

  task automatic send_eop();
    cur_bit = 1'b0;
    eop = 1'b1;
    d_edge = 1'b1;
    tick1();
    d_edge = 1'b0;
    repeat (15) tick1();
    eop = 1'b0;
    d_edge = 1'b1;
    tick1();
    d_edge = 1'b0;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_rcving"}, 32'(rcving), 0);
    chk({tag, "_shift_enable"}, 32'(shift_enable), 0);
    chk({tag, "_byte_received"}, 32'(byte_received), 0);
    chk({tag, "_w_enable"}, 32'(w_enable), 0);
    chk({tag, "_r_error"}, 32'(r_error), 0);
  endtask

  initial begin
    n_rst = 1'b0; d_edge = 1'b0; eop = 1'b0; cur_bit = 1'b0; chk_phase = 1'b1;
    #12;
    chk_outs_zero("reset");
    @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (3) tick1();

    // clean packet: SYNC, 0xA5, EOP
    clr();
    exp_q.push_back(8'hA5);
    send_byte(8'h80, 0);
    send_byte(8'hA5, 0);
    chk("clean_rcving_mid", 32'(rcving), 1);
    send_eop();
    chk("clean_n_br", n_br, 2);
    chk("clean_n_we", n_we, 1);
    chk("clean_n_se", n_se, 16);
    chk("clean_r_error", 32'(r_error), 0);
    chk("clean_rcving_end", 32'(rcving), 0);
    chk("clean_sb_empty", exp_q.size(), 0);

    // bad SYNC byte
    clr();
    send_byte(8'h81, 0);
    chk("badsync_r_error", 32'(r_error), 1);
    send_eop();
    chk("badsync_r_error_idle", 32'(r_error), 1);
    chk("badsync_rcving", 32'(rcving), 0);
    chk("badsync_n_we", n_we, 0);
    repeat (5) tick1();
    chk("badsync_r_error_held", 32'(r_error), 1);

    // next packet clears the error on its first edge, then EOP after 4 data bits
    clr();
    s = 8'h80;
    cur_bit = s[0];
    d_edge = 1'b1;
    tick1();
    chk("restart_r_error", 32'(r_error), 0);
    chk("restart_rcving", 32'(rcving), 1);
    d_edge = 1'b0;
    repeat (7) tick1();
    for (int i = 1; i < 8; i++) send_bit(s[i], 8);
    repeat (4) send_bit(1'b1, 8);
    chk("short_r_error_pre", 32'(r_error), 0);
    send_eop();
    chk("short_r_error", 32'(r_error), 1);
    chk("short_rcving", 32'(rcving), 0);
    chk("short_n_we", n_we, 0);

    // jittered edge spacing of 7 and 9 clocks
    clr();
    exp_q.push_back(8'h3C);
    send_byte(8'h80, 1);
    send_byte(8'h3C, 1);
    send_eop();
    chk("jit_n_se", n_se, 16);
    chk("jit_n_br", n_br, 2);
    chk("jit_n_we", n_we, 1);
    chk("jit_r_error", 32'(r_error), 0);
    chk("jit_sb_empty", exp_q.size(), 0);

    // eight bit times with no edge after SYNC
    chk_phase = 1'b0;
    clr();
    send_byte(8'h80, 0);
`ifndef USB_RX_STUFF_TIMEOUT_EN
    exp_q.push_back(8'hFF);
`endif
    repeat (64) tick1();
`ifdef USB_RX_STUFF_TIMEOUT_EN
    chk("stuff_r_error", 32'(r_error), 1);
    chk("stuff_n_we", n_we, 0);
`else
    chk("stuff_r_error", 32'(r_error), 0);
    chk("stuff_n_br", n_br, 2);
    chk("stuff_n_we", n_we, 1);
`endif
    send_eop();
    chk("stuff_rcving", 32'(rcving), 0);
    chk("stuff_sb_empty", exp_q.size(), 0);
    chk_phase = 1'b1;

    // asynchronous reset while RECEIVE is mid-byte
    clr();
    send_byte(8'h80, 0);
    repeat (3) send_bit(1'b1, 8);
    cur_bit = 1'b0;
    d_edge = 1'b1;
    tick1();
    d_edge = 1'b0;
    repeat (3) tick1();
    chk("midrst_se_before", 32'(shift_enable), 1);
    chk("midrst_rcving_before", 32'(rcving), 1);
    #2 n_rst = 1'b0;
    #1;
    chk_outs_zero("midrst");
    chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
    @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (20) tick1();
    chk("midrst_n_we", n_we, 0);
    chk("midrst_rcving_after", 32'(rcving), 0);
    chk("midrst_state_after", 32'(dut.state_q), 32'(IDLE));
    chk("midrst_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
